// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin switch allocator feeding one output port through a single-entry register
module output_port_arbiter #(
  parameter int DSIZE = 32,
  parameter int NPORTS = 5,
  parameter logic [2:0] PORT = 3'b000,
  parameter int CNTW = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORTS-1:0]       req_valid,
  input  logic [3*NPORTS-1:0]     req_sel,
  input  logic [DSIZE*NPORTS-1:0] req_data,
  output logic [NPORTS-1:0]       req_ack,
  input  logic                    out_full,
  output logic                    out_write,
  output logic [DSIZE-1:0]        out_data,
  output logic [2:0]              grant_id,
  output logic [CNTW-1:0]         grant_count,
  output logic                    uturn_err
);
  logic              out_valid;
  logic              can_load;
  logic              found;
  logic              load;
  logic              uturn;
  logic [2:0]        rr_ptr;
  logic [2:0]        win;
  logic [3:0]        idx;
  logic [NPORTS-1:0] elig;
  // eligibility filter and round-robin search; descending scan so the closest-to-rr_ptr winner is assigned last
  always_comb begin
    elig = '0;
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NPORTS; i++)
      elig[i] = req_valid[i] && req_sel[3*i +: 3] == PORT && i != int'(PORT);
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      idx = idx >= 4'(NPORTS) ? idx - 4'(NPORTS) : idx;
      if (elig[idx[2:0]]) begin
        win = idx[2:0];
        found = 1'b1;
      end
    end
  end
  assign uturn     = req_valid[PORT] && req_sel[3*int'(PORT) +: 3] == PORT;
  assign can_load  = ~out_valid | ~out_full;
  assign load      = can_load & found & ~reset;
  assign req_ack   = load ? NPORTS'(1) << win : '0;
  assign out_write = out_valid & ~out_full;
  // output register, round-robin pointer, grant bookkeeping and sticky u-turn flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      rr_ptr      <= '0;
      grant_id    <= '0;
      grant_count <= '0;
      uturn_err   <= 1'b0;
    end else begin
      if (load) begin
        out_data    <= req_data[DSIZE*int'(win) +: DSIZE];
        out_valid   <= 1'b1;
        rr_ptr      <= win == 3'(NPORTS - 1) ? 3'd0 : win + 3'd1;
        grant_id    <= win;
        grant_count <= grant_count + CNTW'(1);
      end else if (out_write) begin
        out_valid <= 1'b0;
      end
      if (uturn) uturn_err <= 1'b1;
    end
  end
endmodule
